// File: rtl/diagnosis_conf_pkg.sv
// rtl/diagnosis_conf_pkg.sv - shared codes and types for the diagnosis configuration loader
package diagnosis_conf_pkg;

    localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
    localparam logic [1:0] FLIT_HEADER  = 2'b01;
    localparam logic [1:0] FLIT_LAST    = 2'b10;
    localparam logic [1:0] FLIT_SINGLE  = 2'b11;

    localparam logic [2:0] CONF_CLASS = 3'b011;

    // Header data layout: [15:11] dest, [10:8] class, [7:0] src
    localparam int HDR_DEST_LSB  = 11;
    localparam int HDR_CLASS_LSB = 8;

    localparam int CONF_FLITS_PER_ENTRY = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_COMMIT,
        ST_DISCARD
    } conf_state_e;

endpackage

// File: rtl/diagnosis_conf_shadow.sv
// rtl/diagnosis_conf_shadow.sv - shadow word array plus committed configuration image
module diagnosis_conf_shadow #(
    parameter int WORDS = 48,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 wr_en_i,
    input  logic [AW-1:0]        wr_addr_i,
    input  logic [15:0]          wr_data_i,
    input  logic                 commit_i,
    output logic [16*WORDS-1:0]  conf_mem_o
);

    logic [15:0] shadow_q [WORDS];
    logic [15:0] mem_q    [WORDS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) begin
                shadow_q[i] <= '0;
                mem_q[i]    <= '0;
            end
        end else begin
            // Loading from the committed image discards any aborted partial writes
            if (load_i) begin
                for (int i = 0; i < WORDS; i++) begin
                    shadow_q[i] <= mem_q[i];
                end
            end else if (wr_en_i) begin
                shadow_q[wr_addr_i] <= wr_data_i;
            end
            if (commit_i) begin
                for (int i = 0; i < WORDS; i++) begin
                    mem_q[i] <= shadow_q[i];
                end
            end
        end
    end

    always_comb begin
        conf_mem_o = '0;
        for (int i = 0; i < WORDS; i++) begin
            conf_mem_o[16*i +: 16] = mem_q[i];
        end
    end

endmodule

// File: rtl/diagnosis_conf_loader.sv
// rtl/diagnosis_conf_loader.sv - debug NoC receiver committing config-write packets to conf_mem
module diagnosis_conf_loader
    import diagnosis_conf_pkg::*;
#(
    parameter int         PC_EVENTS_MAX         = 8,
    parameter logic [4:0] CORE_ID               = 5'd0,
    parameter int         DBG_NOC_VCHANNELS     = 1,
    parameter int         DBG_NOC_CONF_VCHANNEL = 0,
    localparam int        CONF_WORDS            = 2 * CONF_FLITS_PER_ENTRY * PC_EVENTS_MAX
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [17:0]                  dbgnoc_in_flit,
    input  logic [DBG_NOC_VCHANNELS-1:0] dbgnoc_in_valid,
    output logic [DBG_NOC_VCHANNELS-1:0] dbgnoc_in_ready,
    output logic [16*CONF_WORDS-1:0]     conf_mem,
    output logic                         conf_update,
    output logic                         conf_error
);

    localparam int AW = $clog2(CONF_WORDS);

    conf_state_e state_q;
    logic [15:0] ptr_q;
    logic        ready_q;
    logic        conf_update_q;
    logic        conf_error_q;

    logic [1:0]  ftype;
    logic [15:0] fdata;
    logic        accept;
    logic        hdr_match;
    logic        in_range;
    conf_state_e hdr_next;
    logic        sh_load;
    logic        sh_wr_en;
    logic        sh_commit;

    assign ftype     = dbgnoc_in_flit[17:16];
    assign fdata     = dbgnoc_in_flit[15:0];
    assign accept    = dbgnoc_in_valid[DBG_NOC_CONF_VCHANNEL] && ready_q;
    assign hdr_match = (fdata[HDR_DEST_LSB +: 5] == CORE_ID) &&
                       (fdata[HDR_CLASS_LSB +: 3] == CONF_CLASS);
    assign in_range  = ptr_q < 16'(CONF_WORDS);

    // Same header decode whether we are idle or a packet was cut short
    always_comb begin
        hdr_next = ST_IDLE;
        if (ftype == FLIT_HEADER) begin
            hdr_next = hdr_match ? ST_ADDR : ST_DISCARD;
        end
    end

    always_comb begin
        sh_load   = 1'b0;
        sh_wr_en  = 1'b0;
        sh_commit = (state_q == ST_COMMIT);
        if (accept && ftype == FLIT_HEADER && hdr_match &&
            (state_q == ST_IDLE || state_q == ST_ADDR || state_q == ST_DATA)) begin
            sh_load = 1'b1;
        end
        if (accept && state_q == ST_DATA && in_range &&
            (ftype == FLIT_PAYLOAD || ftype == FLIT_LAST)) begin
            sh_wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            ready_q       <= 1'b1;
            conf_update_q <= 1'b0;
            conf_error_q  <= 1'b0;
        end else begin
            conf_update_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (ftype == FLIT_HEADER || ftype == FLIT_SINGLE) begin
                            state_q <= hdr_next;
                        end else begin
                            conf_error_q <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (accept) begin
                        if (ftype == FLIT_PAYLOAD) begin
                            ptr_q   <= fdata;
                            state_q <= ST_DATA;
                        end else begin
                            conf_error_q <= 1'b1;
                            state_q      <= (ftype == FLIT_LAST) ? ST_IDLE : hdr_next;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        if (ftype == FLIT_PAYLOAD || ftype == FLIT_LAST) begin
                            if (!in_range) begin
                                conf_error_q <= 1'b1;
                            end
                            if (ptr_q != 16'hFFFF) begin
                                ptr_q <= ptr_q + 16'd1;
                            end
                            if (ftype == FLIT_LAST) begin
                                state_q <= ST_COMMIT;
                                ready_q <= 1'b0;
                            end
                        end else begin
                            conf_error_q <= 1'b1;
                            state_q      <= hdr_next;
                        end
                    end
                end
                ST_COMMIT: begin
                    state_q       <= ST_IDLE;
                    ready_q       <= 1'b1;
                    conf_update_q <= 1'b1;
                end
                ST_DISCARD: begin
                    if (accept && ftype == FLIT_LAST) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        dbgnoc_in_ready                        = '0;
        dbgnoc_in_ready[DBG_NOC_CONF_VCHANNEL] = ready_q;
    end

    assign conf_update = conf_update_q;
    assign conf_error  = conf_error_q;

    diagnosis_conf_shadow #(
        .WORDS (CONF_WORDS)
    ) u_shadow (
        .clk        (clk),
        .rst        (rst),
        .load_i     (sh_load),
        .wr_en_i    (sh_wr_en),
        .wr_addr_i  (ptr_q[AW-1:0]),
        .wr_data_i  (fdata),
        .commit_i   (sh_commit),
        .conf_mem_o (conf_mem)
    );

endmodule

// File: tb/tb_diagnosis_conf_loader.sv
// tb/tb_diagnosis_conf_loader.sv - scoreboard bench for diagnosis_conf_loader
module tb_diagnosis_conf_loader;

    localparam int WORDS = 48;
    localparam int CLK_P = 10;
    localparam logic [1:0] T_PAY = 2'b00, T_HDR = 2'b01, T_LAST = 2'b10;
    localparam logic [15:0] HDR_OK  = 16'h0300;
    localparam logic [15:0] HDR_BAD = 16'h0B00;

    typedef struct packed {
        logic [16*WORDS-1:0] mem;
        logic                err;
        logic [63:0]         t;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [17:0]           flit;
    logic [0:0]            valid;
    logic [0:0]            ready;
    logic [16*WORDS-1:0]   conf_mem;
    logic                  conf_update;
    logic                  conf_error;

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        exp_q[$];
    logic [15:0] model [WORDS];
    logic        exp_err;
    logic [63:0] last_acc_t;

    always #(CLK_P/2) clk = ~clk;

    diagnosis_conf_loader dut (
        .clk             (clk),
        .rst             (rst),
        .dbgnoc_in_flit  (flit),
        .dbgnoc_in_valid (valid),
        .dbgnoc_in_ready (ready),
        .conf_mem        (conf_mem),
        .conf_update     (conf_update),
        .conf_error      (conf_error)
    );

    task automatic check(input string name, input logic [16*WORDS-1:0] act,
                         input logic [16*WORDS-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [16*WORDS-1:0] model_flat();
        logic [16*WORDS-1:0] r;
        for (int i = 0; i < WORDS; i++) r[16*i +: 16] = model[i];
        return r;
    endfunction

    task automatic send(input logic [1:0] t, input logic [15:0] d, input logic chk_ready);
        int n = 0;
        @(negedge clk);
        flit  = {t, d};
        valid = 1'b1;
        if (chk_ready) check("ready_high", {767'd0, ready[0]}, {767'd0, 1'b1});
        while (!ready[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready[0]) check("ready_timeout", {767'd0, ready[0]}, {767'd0, 1'b1});
        @(posedge clk);
        last_acc_t = $time;
        #1 valid = 1'b0;
    endtask

    task automatic expect_commit();
        exp_t e;
        e.mem = model_flat();
        e.err = exp_err;
        e.t   = last_acc_t + CLK_P + CLK_P/2;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < WORDS; i++) model[i] = 16'h0;
        exp_err = 1'b0;
    endtask

    // Monitor: every conf_update pulse must match the oldest expected commit
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && conf_update === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_update", {767'd0, conf_update}, 768'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("commit_mem", conf_mem, e.mem);
                    check("commit_err", {767'd0, conf_error}, {767'd0, e.err});
                    check("update_time", {704'd0, 64'($time)}, {704'd0, e.t});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        flit  = '0;
        valid = 1'b0;
        rst   = 1'b1;
        do_reset();
        @(negedge clk);
        check("reset_mem", conf_mem, 768'd0);
        check("reset_update", {767'd0, conf_update}, 768'd0);
        check("reset_error", {767'd0, conf_error}, 768'd0);
        check("reset_ready", {767'd0, ready[0]}, {767'd0, 1'b1});

        // Basic write of words 0 and 1
        send(T_HDR, HDR_OK, 1'b0);
        send(T_PAY, 16'h0000, 1'b0);
        send(T_PAY, 16'h0001, 1'b0);
        send(T_LAST, 16'hBEEF, 1'b0);
        model[0] = 16'h0001;
        model[1] = 16'hBEEF;
        expect_commit();
        @(negedge clk);
        check("ready_low_commit", {767'd0, ready[0]}, 768'd0);

        // Wrong destination is swallowed without backpressure
        send(T_HDR, HDR_BAD, 1'b1);
        for (int i = 0; i < 4; i++) send(T_PAY, 16'h1000 + 16'(i), 1'b1);
        send(T_LAST, 16'hDEAD, 1'b1);
        repeat (4) @(negedge clk);
        check("wrong_dest_mem", conf_mem, model_flat());

        // Partial update keeps untouched words
        send(T_HDR, HDR_OK, 1'b0);
        send(T_PAY, 16'h0005, 1'b0);
        send(T_PAY, 16'hAAAA, 1'b0);
        send(T_LAST, 16'h5555, 1'b0);
        model[5] = 16'hAAAA;
        model[6] = 16'h5555;
        expect_commit();
        send(T_HDR, HDR_OK, 1'b0);
        send(T_PAY, 16'h0006, 1'b0);
        send(T_LAST, 16'h1234, 1'b0);
        model[6] = 16'h1234;
        expect_commit();

        // Out of range: word 47 lands, word 48 dropped with error
        send(T_HDR, HDR_OK, 1'b0);
        send(T_PAY, 16'd47, 1'b0);
        send(T_PAY, 16'h1111, 1'b0);
        send(T_LAST, 16'h2222, 1'b0);
        model[47] = 16'h1111;
        exp_err   = 1'b1;
        expect_commit();

        // Reset in DATA after two payload words
        send(T_HDR, HDR_OK, 1'b0);
        send(T_PAY, 16'h0008, 1'b0);
        send(T_PAY, 16'h0A0A, 1'b0);
        send(T_PAY, 16'h0B0B, 1'b0);
        do_reset();
        repeat (3) @(negedge clk);
        check("mid_reset_mem", conf_mem, 768'd0);
        check("mid_reset_error", {767'd0, conf_error}, 768'd0);
        send(T_HDR, HDR_OK, 1'b0);
        send(T_PAY, 16'h0004, 1'b0);
        send(T_LAST, 16'h4444, 1'b0);
        model[4] = 16'h4444;
        expect_commit();

        // Truncated packet, then the interrupting header runs normally
        send(T_HDR, HDR_OK, 1'b0);
        send(T_PAY, 16'h0002, 1'b0);
        send(T_PAY, 16'h7777, 1'b0);
        send(T_HDR, HDR_OK, 1'b0);
        send(T_PAY, 16'h0003, 1'b0);
        send(T_LAST, 16'h00C3, 1'b0);
        model[3] = 16'h00C3;
        exp_err  = 1'b1;
        expect_commit();

        repeat (6) @(negedge clk);
        check("pending_commits", {736'd0, 32'(exp_q.size())}, 768'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
